// File: rtl/wots_pkg.sv
//==============================================================================
// Module : wots_pkg
// Shared constants for the WOTS chain engine: address layout, SHA-256 length
// field, FSM state encoding and default domain-separation prefixes.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package wots_pkg;

    localparam int ADDR_W        = 256;
    localparam int ADDR_FIELD_W  = 32;
    localparam int ADDR_CHAIN_LSB = 64;
    localparam int ADDR_HASH_LSB  = 32;
    localparam int ADDR_KAM_LSB   = 0;

    localparam logic [63:0]  MSG_LEN_BITS    = 64'd768;
    localparam logic [255:0] DEFAULT_PAD_F   = 256'd0;
    localparam logic [255:0] DEFAULT_PAD_PRF = 256'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQ_KEY   = 3'd1;
    localparam logic [2:0] ST_WAIT_KEY  = 3'd2;
    localparam logic [2:0] ST_REQ_MASK  = 3'd3;
    localparam logic [2:0] ST_WAIT_MASK = 3'd4;
    localparam logic [2:0] ST_REQ_F     = 3'd5;
    localparam logic [2:0] ST_WAIT_F    = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    // Rebuild an address from its upper part (chain field and above) plus new hash/kam fields.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [ADDR_W-ADDR_CHAIN_LSB-1:0] hi,
        input logic [ADDR_FIELD_W-1:0]          hash_idx,
        input logic [ADDR_FIELD_W-1:0]          kam
    );
        logic [ADDR_W-1:0] r;
        r = '0;
        r[ADDR_W-1:ADDR_CHAIN_LSB]             = hi;
        r[ADDR_HASH_LSB +: ADDR_FIELD_W]       = hash_idx;
        r[ADDR_KAM_LSB +: ADDR_FIELD_W]        = kam;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wots_chain_if.sv
//==============================================================================
// Module : wots_chain_if
// Request/response link between the WOTS chain engine and a SHA-256 core.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface wots_chain_if #(
    parameter int KEY_LEN = 256
);
    logic                hash_start;
    logic [1023:0]       hash_data_in;
    logic                message_length;
    logic                continue_intermediate;
    logic                store_intermediate;
    logic                hash_done;
    logic [KEY_LEN-1:0]  hash_data_out;

    modport master (
        output hash_start, hash_data_in, message_length,
               continue_intermediate, store_intermediate,
        input  hash_done, hash_data_out
    );

    modport slave (
        input  hash_start, hash_data_in, message_length,
               continue_intermediate, store_intermediate,
        output hash_done, hash_data_out
    );
endinterface

`default_nettype wire

// File: rtl/wots_msg_fmt.sv
//==============================================================================
// Module : wots_msg_fmt
// Combinational formatter: prefix | key | payload followed by SHA-256 padding
// for a 96-byte message, giving two 512-bit blocks.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module wots_msg_fmt
    import wots_pkg::*;
#(
    parameter int KEY_LEN = 256
)(
    input  wire logic [KEY_LEN-1:0] prefix,
    input  wire logic [KEY_LEN-1:0] key,
    input  wire logic [KEY_LEN-1:0] payload,
    output logic      [1023:0]      msg
);
    localparam int ZPAD_W = 1024 - 3*KEY_LEN - 1 - 64;

    assign msg = {prefix, key, payload, 1'b1, {ZPAD_W{1'b0}}, MSG_LEN_BITS};
endmodule

`default_nettype wire

// File: rtl/wots_chain.sv
//==============================================================================
// Module : wots_chain
// WOTS chain engine: per step, two PRF requests (key, mask) then one F request
// to an external SHA-256 core. Define WOTS_CHAIN_MIDSTATE_EN to drive the
// midstate store/continue hints on PRF requests.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module wots_chain
    import wots_pkg::*;
#(
    parameter int                 WOTS_W                = 16,
    parameter int                 KEY_LEN               = 256,
    parameter int                 WOTS_LOG_W            = $clog2(WOTS_W),
    parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_F   = DEFAULT_PAD_F,
    parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_PRF = DEFAULT_PAD_PRF
)(
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [KEY_LEN-1:0]    input_key,
    input  wire logic [KEY_LEN-1:0]    input_data,
    input  wire logic [WOTS_LOG_W-1:0] start_step,
    input  wire logic [WOTS_LOG_W-1:0] end_step,
    input  wire logic [ADDR_W-1:0]     hash_addr,
    output logic                       busy,
    output logic                       done,
    output logic      [KEY_LEN-1:0]    data_out,
    output logic      [ADDR_W-1:0]     hash_addr_updated,
    wots_chain_if.master               hif
);
    localparam int HI_W = ADDR_W - ADDR_CHAIN_LSB;

    logic [2:0]             state;
    logic [WOTS_LOG_W:0]    step;
    logic [WOTS_LOG_W:0]    end_r;
    logic [WOTS_LOG_W:0]    step_next;
    logic [KEY_LEN-1:0]     seed_r;
    logic [KEY_LEN-1:0]     value_r;
    logic [KEY_LEN-1:0]     key_r;
    logic [KEY_LEN-1:0]     mask_r;
    logic [HI_W-1:0]        addr_hi;

    logic                   is_f;
    logic                   is_mask;
    logic [ADDR_W-1:0]      prf_addr;
    logic [KEY_LEN-1:0]     prefix;
    logic [KEY_LEN-1:0]     fmt_key;
    logic [KEY_LEN-1:0]     payload;
    logic [1023:0]          msg;

    assign step_next = step + 1'b1;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // Message selection depends only on state and registers frozen during WAIT_*,
    // so the request stays stable until the response arrives.
    assign is_f     = (state == ST_REQ_F) || (state == ST_WAIT_F);
    assign is_mask  = (state == ST_REQ_MASK) || (state == ST_WAIT_MASK);
    assign prf_addr = make_addr(addr_hi, ADDR_FIELD_W'(step), is_mask ? 32'd1 : 32'd0);
    assign prefix   = is_f ? XMSS_HASH_PADDING_F : XMSS_HASH_PADDING_PRF;
    assign fmt_key  = is_f ? key_r : seed_r;
    assign payload  = is_f ? (value_r ^ mask_r) : prf_addr;

    wots_msg_fmt #(.KEY_LEN(KEY_LEN)) u_fmt (
        .prefix  (prefix),
        .key     (fmt_key),
        .payload (payload),
        .msg     (msg)
    );

    assign hif.hash_data_in   = msg;
    assign hif.message_length = 1'b1;
    assign hif.hash_start     = (state == ST_REQ_KEY) || (state == ST_REQ_MASK) ||
                                (state == ST_REQ_F);

`ifdef WOTS_CHAIN_MIDSTATE_EN
    logic first_prf;

    always_ff @(posedge clk) begin
        if (reset) begin
            first_prf <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            first_prf <= 1'b1;
        end else if (state == ST_REQ_KEY) begin
            first_prf <= 1'b0;
        end
    end

    assign hif.store_intermediate    = (state == ST_REQ_KEY) && first_prf;
    assign hif.continue_intermediate = ((state == ST_REQ_KEY) && !first_prf) ||
                                       (state == ST_REQ_MASK);
`else
    assign hif.store_intermediate    = 1'b0;
    assign hif.continue_intermediate = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            step              <= '0;
            end_r             <= '0;
            seed_r            <= '0;
            value_r           <= '0;
            key_r             <= '0;
            mask_r            <= '0;
            addr_hi           <= '0;
            data_out          <= '0;
            hash_addr_updated <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_r  <= input_key;
                        value_r <= input_data;
                        addr_hi <= hash_addr[ADDR_W-1:ADDR_CHAIN_LSB];
                        step    <= {1'b0, start_step};
                        end_r   <= {1'b0, end_step};
                        if (end_step <= start_step) begin
                            data_out          <= input_data;
                            hash_addr_updated <= hash_addr;
                            state             <= ST_DONE;
                        end else begin
                            state <= ST_REQ_KEY;
                        end
                    end
                end
                ST_REQ_KEY:  state <= ST_WAIT_KEY;
                ST_WAIT_KEY: begin
                    if (hif.hash_done) begin
                        key_r <= hif.hash_data_out;
                        state <= ST_REQ_MASK;
                    end
                end
                ST_REQ_MASK:  state <= ST_WAIT_MASK;
                ST_WAIT_MASK: begin
                    if (hif.hash_done) begin
                        mask_r <= hif.hash_data_out;
                        state  <= ST_REQ_F;
                    end
                end
                ST_REQ_F:  state <= ST_WAIT_F;
                ST_WAIT_F: begin
                    if (hif.hash_done) begin
                        value_r <= hif.hash_data_out;
                        if (step_next < end_r) begin
                            step  <= step_next;
                            state <= ST_REQ_KEY;
                        end else begin
                            data_out          <= hif.hash_data_out;
                            hash_addr_updated <= make_addr(addr_hi, ADDR_FIELD_W'(step), 32'd0);
                            state             <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_wots_chain.sv
//==============================================================================
// Module : tb_wots_chain
// Directed bench for wots_chain with a fixed-latency toy hash responder.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wots_chain;
    localparam int KL  = 256;
    localparam int LW  = 4;
    localparam int LAT = 10;
    localparam logic [255:0] TAIL = {1'b1, 191'b0, 64'd768};

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [KL-1:0]  input_key;
    logic [KL-1:0]  input_data;
    logic [255:0]   hash_addr;
    logic [LW-1:0]  start_step;
    logic [LW-1:0]  end_step;
    logic           busy;
    logic           done;
    logic [KL-1:0]  data_out;
    logic [255:0]   hash_addr_updated;

    wots_chain_if #(.KEY_LEN(KL)) hif ();

    wots_chain #(.WOTS_W(16), .KEY_LEN(KL)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .input_key         (input_key),
        .input_data        (input_data),
        .start_step        (start_step),
        .end_step          (end_step),
        .hash_addr         (hash_addr),
        .busy              (busy),
        .done              (done),
        .data_out          (data_out),
        .hash_addr_updated (hash_addr_updated),
        .hif               (hif)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rotl(input logic [255:0] x, input int n);
        return (x << n) | (x >> (256 - n));
    endfunction

    function automatic logic [255:0] toy(input logic [1023:0] m);
        logic [255:0] p, k, d, t;
        {p, k, d, t} = m;
        return (p ^ rotl(k, 1) ^ rotl(d, 7) ^ rotl(t, 13)) + {k[127:0], d[255:128]};
    endfunction

    function automatic logic [255:0] golden(input logic [255:0] seed, din, a,
                                            input int s, e);
        logic [255:0] v, key, mask, pa;
        v = din;
        for (int i = s; i < e; i++) begin
            pa   = {a[255:64], 32'(i), 32'd0};
            key  = toy({256'd3, seed, pa, TAIL});
            pa[31:0] = 32'd1;
            mask = toy({256'd3, seed, pa, TAIL});
            v    = toy({256'd0, key, v ^ mask, TAIL});
        end
        return v;
    endfunction

    // Hash core model: answers each request LAT cycles after its hash_start cycle.
    int           cyc = 0;
    int           due = 0;
    int           nreq = 0;
    int           stab_err = 0;
    bit           armed = 1'b0;
    bit           stab_armed = 1'b0;
    bit           store_seen = 1'b0;
    bit           cont_seen = 1'b0;
    logic [1023:0] cap;
    bit           store_log [0:255];
    bit           cont_log  [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        hif.hash_done <= 1'b0;
        if (stab_armed && hif.hash_data_in !== cap) stab_err <= stab_err + 1;
        if (hif.hash_start) begin
            armed      <= 1'b1;
            stab_armed <= 1'b1;
            due        <= cyc + LAT;
            cap        <= hif.hash_data_in;
            hif.hash_data_out <= toy(hif.hash_data_in);
            if (nreq < 256) begin
                store_log[nreq] <= hif.store_intermediate;
                cont_log[nreq]  <= hif.continue_intermediate;
            end
            if (hif.store_intermediate)    store_seen <= 1'b1;
            if (hif.continue_intermediate) cont_seen  <= 1'b1;
            nreq <= nreq + 1;
        end else if (armed && cyc + 1 == due) begin
            hif.hash_done <= 1'b1;
            armed         <= 1'b0;
            stab_armed    <= 1'b0;
        end
        if (reset) stab_armed <= 1'b0;
    end

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [255:0] k, d, a, input int s, e, input int dup_at,
                          output int t0, output int tdone, output logic b1);
        @(negedge clk);
        input_key  = k;
        input_data = d;
        hash_addr  = a;
        start_step = s[LW-1:0];
        end_step   = e[LW-1:0];
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start = 1'b0;
        b1    = busy;
        tdone = -1;
        for (int n = 0; n < 2000; n++) begin
            if (done) begin
                tdone = cyc;
                break;
            end
            start = (n == dup_at);
            if (n == dup_at) begin
                input_data = ~d;
                start_step = 4'd0;
                end_step   = 4'd15;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [255:0] k1, d1, a1, k2, d2, a2;
        logic [5:0]   got_store, got_cont, exp_store, exp_cont;
        int t0, td, base, activity;
        logic b1;

        k1 = {8{32'hA5C3_1F07}};
        d1 = {4{64'h0123_4567_89AB_CDEF}};
        a1 = {160'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0001};
        k2 = {4{64'hFEDC_BA98_7654_3210}};
        d2 = {8{32'h3C3C_5A5A}};
        a2 = {160'h0, 32'h0000_0009, 32'h0000_0007, 32'h0000_0000};

        reset = 1'b1; start = 1'b0;
        input_key = '0; input_data = '0; hash_addr = '0;
        start_step = '0; end_step = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_done",  256'(done), 256'(0));
        chk("rst_hstart", 256'(hif.hash_start), 256'(0));
        chk("rst_store", 256'(hif.store_intermediate), 256'(0));
        chk("rst_cont",  256'(hif.continue_intermediate), 256'(0));
        chk("rst_data",  data_out, 256'(0));
        chk("rst_addr",  hash_addr_updated, 256'(0));
        chk("msg_len",   256'(hif.message_length), 256'(1));
        reset = 1'b0;

        // Empty chain: start == end
        base = nreq;
        run_op(k1, d1, a1, 3, 3, -1, t0, td, b1);
        chk("n0_busy",     256'(b1), 256'(1));
        chk("n0_done_cyc", 256'(td), 256'(t0 + 1));
        chk("n0_data",     data_out, d1);
        chk("n0_addr",     hash_addr_updated, a1);
        @(negedge clk);
        chk("n0_pulse",    256'(done), 256'(0));
        chk("n0_idle",     256'(busy), 256'(0));
        chk("n0_noreq",    256'(nreq - base), 256'(0));

        // end < start also completes immediately
        base = nreq;
        run_op(k2, d2, a2, 5, 2, -1, t0, td, b1);
        chk("neg_done_cyc", 256'(td), 256'(t0 + 1));
        chk("neg_data",     data_out, d2);
        chk("neg_noreq",    256'(nreq - base), 256'(0));

        // Single step
        base = nreq;
        run_op(k1, d1, a1, 0, 1, -1, t0, td, b1);
        chk("s1_done_cyc", 256'(td), 256'(t0 + 34));
        chk("s1_reqs",     256'(nreq - base), 256'(3));
        chk("s1_data",     data_out, golden(k1, d1, a1, 0, 1));
        chk("s1_addr",     hash_addr_updated, {a1[255:64], 32'd0, 32'd0});

        // Full-length chain up to WOTS_W-1
        base = nreq;
        run_op(k2, d1, a1, 0, 15, -1, t0, td, b1);
        chk("s15_done_cyc", 256'(td), 256'(t0 + 496));
        chk("s15_reqs",     256'(nreq - base), 256'(45));
        chk("s15_data",     data_out, golden(k2, d1, a1, 0, 15));
        chk("s15_addr",     hash_addr_updated, {a1[255:64], 32'd14, 32'd0});

        // Two steps with an ignored second start while busy
        base = nreq;
        run_op(k1, d2, a2, 2, 4, 3, t0, td, b1);
        chk("dup_done_cyc", 256'(td), 256'(t0 + 67));
        chk("dup_reqs",     256'(nreq - base), 256'(6));
        chk("dup_data",     data_out, golden(k1, d2, a2, 2, 4));
        chk("dup_addr",     hash_addr_updated, {a2[255:64], 32'd3, 32'd0});
        for (int i = 0; i < 6; i++) begin
            got_store[i] = store_log[base + i];
            got_cont[i]  = cont_log[base + i];
        end
`ifdef WOTS_CHAIN_MIDSTATE_EN
        exp_store = 6'b000001;
        exp_cont  = 6'b011010;
`else
        exp_store = 6'b000000;
        exp_cont  = 6'b000000;
`endif
        chk("mid_store", 256'(got_store), 256'(exp_store));
        chk("mid_cont",  256'(got_cont),  256'(exp_cont));

        // Reset while waiting for the mask; its response arrives two cycles later
        @(negedge clk);
        base = nreq;
        input_key = k2; input_data = d2; hash_addr = a2;
        start_step = 4'd0; end_step = 4'd1;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", 256'(busy), 256'(0));
        chk("mrst_done", 256'(done), 256'(0));
        chk("mrst_data", data_out, 256'(0));
        chk("mrst_addr", hash_addr_updated, 256'(0));
        activity = 0;
        repeat (15) begin
            if (busy || hif.hash_start || done) activity++;
            @(negedge clk);
        end
        chk("mrst_quiet", 256'(activity), 256'(0));
        chk("mrst_reqs",  256'(nreq - base), 256'(2));

        base = nreq;
        run_op(k2, d2, a2, 1, 2, -1, t0, td, b1);
        chk("post_done_cyc", 256'(td), 256'(t0 + 34));
        chk("post_reqs",     256'(nreq - base), 256'(3));
        chk("post_data",     data_out, golden(k2, d2, a2, 1, 2));
        chk("post_addr",     hash_addr_updated, {a2[255:64], 32'd1, 32'd0});

        chk("stable_msg", 256'(stab_err), 256'(0));
`ifdef WOTS_CHAIN_MIDSTATE_EN
        chk("store_seen", 256'(store_seen), 256'(1));
        chk("cont_seen",  256'(cont_seen),  256'(1));
`else
        chk("store_seen", 256'(store_seen), 256'(0));
        chk("cont_seen",  256'(cont_seen),  256'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wots_chain.md
WOTS_CHAIN -- requirements
Module: wots_chain

Interface
REQ-001 Parameters: WOTS_W, default 16, Winternitz parameter; KEY_LEN, default 256, key/data width; WOTS_LOG_W, default CLOG2(WOTS_W), step-index width; XMSS_HASH_PADDING_F, default 256'd0, F domain prefix; XMSS_HASH_PADDING_PRF, default 256'd3, PRF domain prefix.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle request pulse; sampled only when busy=0.
REQ-005 input_key  in  KEY_LEN  public seed.
REQ-006 input_data  in  KEY_LEN  chain input value.
REQ-007 start_step, end_step  in  WOTS_LOG_W each  first step index, exclusive end index.
REQ-008 hash_addr  in  256  address; chain field [95:64], hash field [63:32], key_and_mask field [31:0].
REQ-009 busy  out  1  operation in progress; done  out  1  one-cycle completion pulse.
REQ-010 data_out  out  KEY_LEN  chain result; hash_addr_updated  out  256  final address.
REQ-011 hash_start  out  1  one-cycle SHA-256 request; hash_data_in  out  1024  two padded 512-bit blocks; message_length  out  1  1 = 96-byte message.
REQ-012 continue_intermediate, store_intermediate  out  1 each  midstate reuse controls.
REQ-013 hash_done  in  1  one-cycle response pulse; hash_data_out  in  KEY_LEN  digest.

Function
REQ-014 On start with busy=0: latch all inputs; busy=1 next cycle; step counter i=start_step.
REQ-015 If end_step <= start_step: no hash request; done=1 and data_out=input_data one cycle after start; hash_addr_updated=latched hash_addr.
REQ-016 Per step i: hash field=i; key=PRF(input_key, addr with key_and_mask=0); mask=PRF(input_key, addr with key_and_mask=1); value=F(key, value XOR mask).
REQ-017 FSM: IDLE -> REQ_KEY -> WAIT_KEY -> REQ_MASK -> WAIT_MASK -> REQ_F -> WAIT_F -> (i+1<end_step ? REQ_KEY : DONE) -> IDLE.
REQ-018 REQ_* states: hash_start=1 for exactly one cycle, then WAIT_*; WAIT_* exits on the hash_done cycle, capturing hash_data_out.
REQ-019 hash_data_in = {prefix, key, payload, 1'b1, 191'b0, 64'd768}; prefix=PRF padding for PRF, F padding for F; PRF payload=address, F payload=value XOR mask; message_length=1 always.
REQ-020 hash_data_in held stable from hash_start until hash_done.
REQ-021 Timing, hash latency L (hash_done L cycles after hash_start): next hash_start one cycle after each hash_done; done at t0+1+3N(L+1), N=end_step-start_step.
REQ-022 On done: data_out holds result until next start; hash_addr_updated = latched address with hash field=end_step-1, key_and_mask=0.
REQ-023 start while busy=1 ignored; hash_done in IDLE, DONE or REQ_* ignored.
REQ-024 Step counter WOTS_LOG_W+1 bits wide; end_step=WOTS_W-1 terminates without wrap.

Reset
REQ-025 reset forces IDLE; busy, done, hash_start, store_intermediate, continue_intermediate=0; data_out, hash_addr_updated, counter=0.
REQ-026 Reset mid-operation abandons the chain; next cycle accepts start; any late hash_done ignored.

Configuration
REQ-027 Macro WOTS_CHAIN_MIDSTATE_EN defined: store_intermediate=1 with the first PRF request of each operation, continue_intermediate=1 with every later PRF request, both 0 for F.
REQ-028 Macro undefined: store_intermediate and continue_intermediate tied 0; every request is a full two-block hash; timing per REQ-021 unchanged relative to hash_done.

Structure
REQ-029 Package wots_pkg: address field offsets, 64'd768 length constant, FSM state enum, padding defaults.
REQ-030 One sub-module wots_msg_fmt: combinational 1024-bit message formatter (prefix, key, payload).

Verification
REQ-031 start_step=3, end_step=3 -> no hash_start; done at t0+1; data_out=input_data.
REQ-032 start_step=0, end_step=1, L=10 -> exactly 3 hash_start pulses; done at t0+34; data_out matches golden F(PRF0,in XOR PRF1).
REQ-033 start_step=0, end_step=15, L=10 -> 45 requests; done at t0+496; hash_addr_updated[63:32]=14, [31:0]=0; matches golden.
REQ-034 Second start while busy -> ignored; result and request count as single operation.
REQ-035 Reset asserted in WAIT_MASK, hash_done 2 cycles later -> stays IDLE, busy=0, no further hash_start; new start then completes correctly.
REQ-036 Macro off vs on, 2-step chain -> off: store/continue never 1; on: store with request 1, continue with PRF requests 2,4,5.
